ral_reg_bank: RTL
=================

Name: ral_reg_bank

Overview:
Parametrised register bank that terminates the RAL register bus (addr / wr_en / wdata / rdata) and adds a valid/ready request channel, a response channel with configurable read latency, and byte strobes. Holds NUM_REGS software registers, each either RW (software-owned) or RO (mirrors a hardware status input). Sits between the bus agent and block logic; its register map is the DUT model for the RAL environment.

Parameters:
ADDR_W, 32, request address width
DATA_W, 32, data width; multiple of 8, 8..64
NUM_REGS, 8, number of registers, 1..64
BASE_ADDR, 0, byte address of register 0; registers at BASE_ADDR + i*(DATA_W/8)
RD_LATENCY, 1, cycles from request accept to rsp_valid, 1..4 (applies to writes too)
RO_MASK, 0, NUM_REGS-bit vector; bit i=1 makes register i read-only
RST_VAL, 0, DATA_W reset value of every RW register

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
addr  in  ADDR_W  byte address
wr_en  in  1  1=write, 0=read
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte enables for writes
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rdata  out  DATA_W  read data, valid with rsp_valid
rsp_err  out  1  error flag, valid with rsp_valid
reg_out  out  NUM_REGS*DATA_W  current value of all registers, reg i at [i*DATA_W +: DATA_W]
hw_status  in  NUM_REGS*DATA_W  source values for RO registers (slices of RW registers unused)
wr_pulse  out  NUM_REGS  one-cycle pulse, register i written

Behaviour:
- Reset (reset=0, async): state IDLE-pending; req_ready=0, rsp_valid=0, rdata=0, rsp_err=0, wr_pulse=0, all RW registers=RST_VAL.
- req_ready registered; rises on first clk edge after reset release; is 1 only in IDLE.
- States: IDLE -> (accept) -> WAIT -> (counter done) -> RESP -> (rsp handshake) -> IDLE. One outstanding transaction only.
- Accept edge: capture wr_en, decoded index, in-range flag; write path commits on this same edge.
- Decode: in range iff addr >= BASE_ADDR, (addr-BASE_ADDR) aligned to DATA_W/8, index < NUM_REGS. Unaligned or out-of-range = invalid.
- Write to valid RW register: each byte with wstrb=1 updated from wdata, others held; wr_pulse[i]=1 for the cycle after accept edge, even if wstrb=0. Write to RO or invalid: no state change, no wr_pulse.
- Read: captures register value (RO: hw_status slice) at accept edge; later hw_status changes do not alter the returned rdata. Invalid read returns 0. Writes return rdata=0.
- Latency: rsp_valid rises exactly RD_LATENCY edges after accept edge; WAIT counter loads RD_LATENCY-1 (RD_LATENCY=1 skips WAIT).
- rsp_valid, rdata, rsp_err held stable until rsp_ready=1; on handshake edge rsp_valid->0, rdata->0, req_ready->1. Back-to-back throughput: one transaction per RD_LATENCY+2 cycles minimum.
- Inputs on req channel ignored outside IDLE.
- Reset mid-transaction: transaction discarded, no response; a write already past its accept edge remains reset to RST_VAL.
- reg_out always reflects RW register contents; RO slices of reg_out show hw_status combinationally.

Optional Feature:
Macro RAL_REG_BANK_ERR_EN. Defined: rsp_err=1 for invalid address (read or write) and for writes to RO registers; 0 otherwise. Not defined: rsp_err tied to 0; same silent ignore/zero-read behaviour.

Test Plan:
- Reset: assert reset=0 mid-run -> all outputs 0, reg_out RW slices = RST_VAL; req_ready=1 one edge after release.
- Write addr=0x4, wdata=0xDEADBEEF, wstrb=0xF, then read 0x4 -> rdata=0xDEADBEEF, wr_pulse[1] single-cycle pulse, rsp_err=0.
- Byte strobe: reg1=0xDEADBEEF, write 0x11223344 wstrb=0x5 -> read 0xDE22BE44.
- Latency/backpressure: RD_LATENCY=3, hold rsp_ready=0 five cycles -> rsp_valid exactly 3 edges after accept, rdata stable, req_ready=0 until handshake.
- RO register: RO_MASK bit 2 set, hw_status slice 0xA5A5; write 0xFFFF to 0x8 then read -> 0xA5A5, no wr_pulse; change hw_status after accept -> returned value unchanged.
- Invalid address 0x22 (unaligned) and 0x40 (index 16) -> read rdata=0, write no effect; rsp_err=1 with RAL_REG_BANK_ERR_EN, 0 without.

Source files
------------

// File: rtl/ral_reg_bank.sv
// ral_reg_bank
//   Register bank terminating the RAL register bus. Requests arrive on a
//   valid/ready channel; every request (read or write) gets one response on
//   the rsp channel RD_LATENCY clock edges after it is accepted. Only one
//   transaction is in flight at a time.
//
//   Build option: define RAL_REG_BANK_ERR_EN to report rsp_err=1 for invalid
//   addresses and for writes to read-only registers. Without it rsp_err is
//   always 0 and such accesses are silently ignored (reads return 0).
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous reset, active low
//   req_valid  : request valid
//   req_ready  : request accepted when req_valid && req_ready (IDLE only)
//   addr       : byte address
//   wr_en      : 1 = write, 0 = read
//   wdata      : write data
//   wstrb      : byte enables for writes
//   rsp_valid  : response valid
//   rsp_ready  : response consumed when rsp_valid && rsp_ready
//   rdata      : read data (0 for writes and invalid reads)
//   rsp_err    : error flag, valid with rsp_valid
//   reg_out    : all register values, reg i at [i*DATA_W +: DATA_W]
//   hw_status  : source values for read-only registers
//   wr_pulse   : one-cycle pulse per register written
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for a request; req_ready=1 (from first edge after reset)
// ST_WAIT | request accepted, counting down the response latency
// ST_RESP | response presented, waiting for rsp_ready

module ral_reg_bank #(
  parameter int                  ADDR_W     = 32,
  parameter int                  DATA_W     = 32,
  parameter int                  NUM_REGS   = 8,
  parameter logic [ADDR_W-1:0]   BASE_ADDR  = '0,
  parameter int                  RD_LATENCY = 1,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
  parameter logic [DATA_W-1:0]   RST_VAL    = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            addr,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          wstrb,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rdata,
  output logic                         rsp_err,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_status,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_W-1:0]     rd_hold;
  logic                  err_hold;

  logic [DATA_W-1:0]     regs [NUM_REGS];
  logic [DATA_W-1:0]     cur  [NUM_REGS];

  logic [ADDR_W-1:0]     offset;
  logic [ADDR_W-1:0]     word;
  logic                  in_range;
  logic                  sel_ro;
  logic [DATA_W-1:0]     sel_val;
  logic                  accept;
  logic [NUM_REGS-1:0]   wr_hit;
  logic                  err_nxt;

  // Visible register value: RO registers follow hw_status live.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cur[i] = RO_MASK[i] ? hw_status[i*DATA_W +: DATA_W] : regs[i];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*DATA_W +: DATA_W] = cur[g];
  end

  // Address decode. Division/modulo are by a constant, so DATA_W need not
  // be a power-of-two number of bytes.
  always_comb begin
    offset   = addr - BASE_ADDR;
    word     = offset / ADDR_W'(BYTES);
    in_range = (addr >= BASE_ADDR) &&
               ((offset % ADDR_W'(BYTES)) == '0) &&
               (word < ADDR_W'(NUM_REGS));
    sel_ro   = 1'b0;
    sel_val  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (in_range && (word == ADDR_W'(i))) begin
        sel_ro  = RO_MASK[i];
        sel_val = cur[i];
      end
    end
  end

  // req_ready is only ever 1 in ST_IDLE, so no state qualifier is needed.
  assign accept = req_valid && req_ready;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_hit[i] = accept && wr_en && in_range &&
                  (word == ADDR_W'(i)) && !RO_MASK[i];
    end
  end

`ifdef RAL_REG_BANK_ERR_EN
  assign err_nxt = !in_range || (wr_en && sel_ro);
`else
  assign err_nxt = 1'b0;
`endif

  // Software registers; writes commit on the accept edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RST_VAL;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[i]) begin
          for (int b = 0; b < BYTES; b++) begin
            if (wstrb[b]) begin
              regs[i][b*8 +: 8] <= wdata[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Transaction FSM. Read data is snapshotted at accept into rd_hold and
  // only moved onto rdata when the response is presented.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rdata     <= '0;
      rsp_err   <= 1'b0;
      wr_pulse  <= '0;
      cnt       <= '0;
      rd_hold   <= '0;
      err_hold  <= 1'b0;
    end else begin
      wr_pulse <= wr_hit;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            cnt       <= CNT_W'(RD_LATENCY - 1);
            rd_hold   <= (in_range && !wr_en) ? sel_val : '0;
            err_hold  <= err_nxt;
            state     <= ST_WAIT;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            rsp_valid <= 1'b1;
            rdata     <= rd_hold;
            rsp_err   <= err_hold;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rdata     <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
